// File: rtl/peripheral_apb4_sram_slave.sv
// APB4 completer over a byte-wide register bank; ACCESS lasts WAIT_STATES+1 cycles.
// Out-of-range addresses complete with pslverr and no memory effect; a dropped psel aborts the transfer.
module peripheral_apb4_sram_slave #(
  parameter int PADDR_SIZE  = 16,
  parameter int PDATA_SIZE  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [PADDR_SIZE-1:0] paddr,
  input  logic                  pwrite,
  input  logic [1:0]            pstrb,
  input  logic [PDATA_SIZE-1:0] pwdata,
  output logic [PDATA_SIZE-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PADDR_SIZE:0] DEPTH_W = (PADDR_SIZE + 1)'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  write_q, write_d;
  logic [PDATA_SIZE-1:0] wdata_q, wdata_d;
  logic                  strb_q, strb_d;
  logic                  err_q, err_d;
  logic [PDATA_SIZE-1:0] prdata_q, prdata_d;

  logic [PDATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]         paddr_idx;
  logic                  paddr_err;
  logic                  complete;
  logic                  mem_we;
  logic                  unused_pstrb;

  assign unused_pstrb = pstrb[1];
  assign paddr_idx    = paddr[AW-1:0];
  assign paddr_err    = ({1'b0, paddr} >= DEPTH_W);

  assign pready   = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign pslverr  = pready && err_q;
  assign prdata   = prdata_q;
  assign complete = pready && psel && penable;
  assign mem_we   = complete && write_q && !err_q && strb_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    case (state_q)
      ST_IDLE: begin
        // Only a true SETUP cycle starts a transfer; a stray penable is ignored.
        if (psel && !penable) begin
          state_d = ST_ACCESS;
          addr_d  = paddr_idx;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb[0];
          err_d   = paddr_err;
          cnt_d   = 4'(WAIT_STATES);
          if (!pwrite) begin
            prdata_d = paddr_err ? '0 : mem[paddr_idx];
          end
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  // Storage is deliberately left unreset; a reset mid-write never reaches the completion edge.
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_peripheral_apb4_sram_slave.sv
// Bench for peripheral_apb4_sram_slave: three instances with 0, 1 and 2 wait states share the bus,
// each selected by its own psel bit; expected responses queue up at issue and are checked at pready.
module tb_peripheral_apb4_sram_slave;

  localparam int DEPTH = 256;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [2:0]  psel;
  logic        penable;
  logic [15:0] paddr;
  logic        pwrite;
  logic [1:0]  pstrb;
  logic [7:0]  pwdata;
  logic [7:0]  prdata_w  [3];
  logic        pready_w  [3];
  logic        pslverr_w [3];

  always #5 pclk = ~pclk;

  peripheral_apb4_sram_slave #(.PADDR_SIZE(16), .PDATA_SIZE(8), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]));

  peripheral_apb4_sram_slave #(.PADDR_SIZE(16), .PDATA_SIZE(8), .DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]));

  peripheral_apb4_sram_slave #(.PADDR_SIZE(16), .PDATA_SIZE(8), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata_w[2]), .pready(pready_w[2]), .pslverr(pslverr_w[2]));

  typedef struct {
    logic       rd;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] model_mem [3][DEPTH];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge with the bus released,
  // so consecutive calls produce back-to-back transfers.
  task automatic xfer(input int d, input logic [15:0] a, input logic wr,
                      input logic [7:0] wd, input logic [1:0] st);
    exp_t e;
    exp_t got;
    int   n;
    bit   done;
    e.rd    = !wr;
    e.err   = (int'(a) >= DEPTH);
    e.rdata = (wr || e.err) ? 8'h00 : model_mem[d][a[7:0]];
    if (wr && !e.err && st[0]) model_mem[d][a[7:0]] = wd;
    sb.push_back(e);
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    paddr   = a;
    pwrite  = wr;
    pwdata  = wd;
    pstrb   = st;
    @(negedge pclk);
    chk("setup_pready", pready_w[d], 0);
    chk("setup_pslverr", pslverr_w[d], 0);
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = ~a;
    pwdata  = ~wd;
    pstrb   = ~st;
    n    = 1;
    done = 0;
    while (!done && n <= 20) begin
      @(negedge pclk);
      if (pready_w[d]) begin
        done = 1;
        got  = sb.pop_front();
        chk("latency", n, d + 1);
        chk("pslverr", pslverr_w[d], got.err);
        if (got.rd) chk("prdata", prdata_w[d], got.rdata);
      end else begin
        @(posedge pclk); #1;
        n++;
      end
    end
    if (!done) begin
      chk("timeout_pready", pready_w[d], 1);
      void'(sb.pop_front());
    end
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    presetn = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pstrb   = 2'b00;
    pwdata  = '0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_pready", pready_w[d], 0);
      chk("rst_pslverr", pslverr_w[d], 0);
      chk("rst_prdata", prdata_w[d], 0);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle(1);

    // One wait state: write then immediate read-back
    xfer(1, 16'h0003, 1, 8'h5A, 2'b01);
    xfer(1, 16'h0003, 0, 8'h00, 2'b01);

    // Zero wait states, back-to-back with read-after-write
    xfer(0, 16'h0000, 1, 8'h11, 2'b01);
    xfer(0, 16'h00FF, 1, 8'h22, 2'b01);
    xfer(0, 16'h0000, 0, 8'h00, 2'b01);
    xfer(0, 16'h00FF, 0, 8'h00, 2'b01);

    // Out of range: error response, no memory effect, read data forced to zero
    xfer(0, 16'h0100, 1, 8'hFF, 2'b01);
    xfer(0, 16'h0100, 0, 8'h00, 2'b01);
    xfer(0, 16'hFFFF, 0, 8'h00, 2'b01);
    xfer(0, 16'h0000, 0, 8'h00, 2'b01);

    // Masked strobe completes cleanly without writing
    xfer(0, 16'h0000, 1, 8'h77, 2'b10);
    xfer(0, 16'h0000, 0, 8'h00, 2'b01);

    // Abort during first ACCESS cycle with two wait states
    xfer(2, 16'h0004, 1, 8'h44, 2'b01);
    idle(1);
    psel    = 3'b100;
    penable = 1'b0;
    paddr   = 16'h0004;
    pwrite  = 1'b1;
    pwdata  = 8'h99;
    pstrb   = 2'b01;
    @(posedge pclk); #1;
    psel    = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("abort_pready", pready_w[2], 0);
    end
    @(posedge pclk); #1;
    xfer(2, 16'h0004, 0, 8'h00, 2'b01);

    // Stray penable in IDLE must not start a transfer
    psel    = 3'b010;
    penable = 1'b1;
    paddr   = 16'h0003;
    pwrite  = 1'b1;
    pwdata  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("badseq_pready", pready_w[1], 0);
    end
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    xfer(1, 16'h0003, 0, 8'h00, 2'b01);

    // Reset in the completing ACCESS cycle drops the pending write
    xfer(1, 16'h0010, 1, 8'h3C, 2'b01);
    xfer(1, 16'h0010, 0, 8'h00, 2'b01);
    psel    = 3'b010;
    penable = 1'b0;
    paddr   = 16'h0010;
    pwrite  = 1'b1;
    pwdata  = 8'hA5;
    pstrb   = 2'b01;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #3;
    presetn = 1'b0;
    #1;
    chk("midrst_pready", pready_w[1], 0);
    chk("midrst_pslverr", pslverr_w[1], 0);
    chk("midrst_prdata", prdata_w[1], 0);
    @(posedge pclk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    presetn = 1'b1;
    idle(1);
    xfer(1, 16'h0010, 0, 8'h00, 2'b01);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
